// File: rtl/tmds_dc_balance.sv
// tmds_dc_balance: TMDS stage-2 DC balancing with running disparity and control-token substitution.
// Optional debug port o_disparity is enabled by defining TMDS_DISP_DBG_EN.
module tmds_dc_balance #(
    parameter int CNT_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_de,
    input  logic [1:0]        i_ctrl,
    input  logic [8:0]        i_qm,
    output logic [9:0]        o_tmds
`ifdef TMDS_DISP_DBG_EN
    ,
    output logic [CNT_W-1:0]  o_disparity
`endif
);
    logic signed [CNT_W-1:0] cnt, cnt_next, n1, diff, two_x, two_nx;
    logic [9:0] sym_next, token;
    logic case_a, case_b;
    always_comb begin
        n1       = CNT_W'($countones(i_qm[7:0]));
        diff     = (n1 <<< 1) - CNT_W'(8);
        two_x    = {{(CNT_W-2){1'b0}}, i_qm[8], 1'b0};
        two_nx   = {{(CNT_W-2){1'b0}}, ~i_qm[8], 1'b0};
        case_a   = (cnt == '0) || (diff == '0);
        // cnt and N1-N0 of the same sign: invert so the symbol pulls the count back toward zero
        case_b   = ((cnt > 0) && (diff > 0)) || ((cnt < 0) && (diff < 0));
        token    = i_ctrl == 2'b00 ? 10'h354 :
                   i_ctrl == 2'b01 ? 10'h0AB :
                   i_ctrl == 2'b10 ? 10'h154 : 10'h2AB;
        sym_next = !i_de  ? token :
                   case_a ? {~i_qm[8], i_qm[8], i_qm[8] ? i_qm[7:0] : ~i_qm[7:0]} :
                   case_b ? {1'b1, i_qm[8], ~i_qm[7:0]} :
                            {1'b0, i_qm[8], i_qm[7:0]};
        cnt_next = !i_de  ? '0 :
                   case_a ? cnt + (i_qm[8] ? diff : -diff) :
                   case_b ? cnt + two_x - diff :
                            cnt - two_nx + diff;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tmds <= 10'h354;
            cnt    <= '0;
        end else begin
            o_tmds <= sym_next;
            cnt    <= cnt_next;
        end
    end
`ifdef TMDS_DISP_DBG_EN
    assign o_disparity = cnt;
`endif
endmodule

// File: tb/tb_tmds_dc_balance.sv
// tb_tmds_dc_balance: directed table, corner sequences and random stream against a symbol-level model.
module tb_tmds_dc_balance;
    logic i_clk = 1'b0, i_rst_n = 1'b0, i_de = 1'b0;
    logic [1:0] i_ctrl = 2'b00;
    logic [8:0] i_qm = '0;
    logic [9:0] o_tmds;
`ifdef TMDS_DISP_DBG_EN
    logic [4:0] o_disparity;
`endif
    int total = 0, bad = 0, mcnt = 0, obs = 0;
    logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    tmds_dc_balance #(.CNT_W(5)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_de(i_de), .i_ctrl(i_ctrl), .i_qm(i_qm),
`ifdef TMDS_DISP_DBG_EN
        .o_disparity(o_disparity),
`endif
        .o_tmds(o_tmds));

    always #5 i_clk = ~i_clk;

    typedef struct {logic de; logic [1:0] ctrl; logic [8:0] qm; logic [9:0] exp; int dsp;} vec_t;
    vec_t vecs [11];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: invert data when the word would push the running disparity further from zero;
    // the count then advances by ones-minus-zeros of the emitted symbol.
    task automatic model_step(input logic de, input logic [1:0] ctrl, input logic [8:0] qm, output logic [9:0] sym);
        int d;
        logic inv;
        if (!de) begin
            mcnt = 0;
            sym = tok[ctrl];
            return;
        end
        d = 2 * $countones(qm[7:0]) - 8;
        inv = (mcnt == 0 || d == 0) ? !qm[8] : ((mcnt > 0) == (d > 0));
        sym = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
        mcnt += 2 * $countones(sym) - 10;
    endtask

    task automatic step(input logic de, input logic [1:0] ctrl, input logic [8:0] qm, input string nm);
        logic [9:0] e;
        @(negedge i_clk);
        i_de = de; i_ctrl = ctrl; i_qm = qm;
        model_step(de, ctrl, qm, e);
        @(posedge i_clk);
        #1;
        check(nm, int'(o_tmds), int'(e));
        obs = de ? obs + 2 * $countones(o_tmds) - 10 : 0;
        check({nm, "_bound"}, int'(obs > 8 || obs < -8), 0);
`ifdef TMDS_DISP_DBG_EN
        check({nm, "_disp"}, int'($signed(o_disparity)), mcnt);
`endif
    endtask

    task automatic reset_pulse();
        #1 i_rst_n = 1'b0;
        #1;
        check("async_reset_tmds", int'(o_tmds), 'h354);
`ifdef TMDS_DISP_DBG_EN
        check("async_reset_disp", int'(o_disparity), 0);
`endif
        mcnt = 0; obs = 0;
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        logic de;
        vecs = '{
            '{1'b0, 2'b00, 9'h000, 10'h354, 0},
            '{1'b0, 2'b01, 9'h1AA, 10'h0AB, 0},
            '{1'b0, 2'b10, 9'h055, 10'h154, 0},
            '{1'b0, 2'b11, 9'h0FF, 10'h2AB, 0},
            '{1'b1, 2'b00, 9'h100, 10'h100, -8},
            '{1'b1, 2'b00, 9'h100, 10'h3FF, 2},
            '{1'b1, 2'b00, 9'h100, 10'h100, -6},
            '{1'b1, 2'b00, 9'h100, 10'h3FF, 4},
            '{1'b0, 2'b00, 9'h100, 10'h354, 0},
            '{1'b1, 2'b00, 9'h0F0, 10'h20F, 0},
            '{1'b1, 2'b00, 9'h0F0, 10'h20F, 0}};
        i_de = 1'($urandom); i_ctrl = 2'($urandom); i_qm = 9'($urandom);
        #23;
        check("reset_tmds", int'(o_tmds), 'h354);
`ifdef TMDS_DISP_DBG_EN
        check("reset_disp", int'(o_disparity), 0);
`endif
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].de, vecs[i].ctrl, vecs[i].qm, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_const", i), int'(o_tmds), int'(vecs[i].exp));
`ifdef TMDS_DISP_DBG_EN
            check($sformatf("vec%0d_cnt", i), int'($signed(o_disparity)), vecs[i].dsp);
`endif
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 9'h0F0, "bal_px");
            check("bal_const", int'(o_tmds), 'h20F);
            step(1'b0, 2'b00, 9'h0F0, "bal_blank");
        end
        step(1'b0, 2'b00, 9'h000, "mid_blank");
        step(1'b1, 2'b00, 9'h100, "mid_px0");
        step(1'b1, 2'b00, 9'h100, "mid_px1");
        check("mid_px1_const", int'(o_tmds), 'h3FF);
        reset_pulse();
        step(1'b1, 2'b00, 9'h100, "post_rst");
        check("post_rst_const", int'(o_tmds), 'h100);
        de = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 19) == 0) de = !de;
            step(de, 2'($urandom), 9'($urandom), "rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
